// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
//   state_t    : scan FSM states
//   slot_t     : per-slot decode request captured on BLANK entry
//   SEG_OFF    : all segments and dp dark (active-low)
//   SEG_BLANK7 : all seven segments dark
//   DP_BIT     : bit position of the decimal point in seg
//   MAX_BCD    : largest displayable BCD code
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [6:0] SEG_BLANK7 = 7'h7F;
  localparam int         DP_BIT     = 7;
  localparam logic [3:0] MAX_BCD    = 4'd9;

  typedef struct packed {
    logic       dp_n;   // active-low dp for this slot
    logic       blank;  // force segments dark (bad code or leading zero)
    logic [3:0] code;   // BCD code fed to the shared decoder
  } slot_t;

endpackage

// File: rtl/bcd_7seg.sv
// bcd_7seg: BCD to common-anode 7-segment decoder (active-low).
//   bcd     [3:0] : BCD code, 0..9 decoded, anything else dark
//   display [7:0] : {dp, g, f, e, d, c, b, a}, active-low; dp always off
module bcd_7seg (
  input  logic [3:0] bcd,
  output logic [7:0] display
);

  always_comb begin
    display = 8'hFF;
    unique case (bcd)
      4'd0:    display[6:0] = 7'h40;
      4'd1:    display[6:0] = 7'h79;
      4'd2:    display[6:0] = 7'h24;
      4'd3:    display[6:0] = 7'h30;
      4'd4:    display[6:0] = 7'h19;
      4'd5:    display[6:0] = 7'h12;
      4'd6:    display[6:0] = 7'h02;
      4'd7:    display[6:0] = 7'h78;
      4'd8:    display[6:0] = 7'h00;
      4'd9:    display[6:0] = 7'h10;
      default: display[6:0] = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display sharing one bcd_7seg decoder.
//   clk, rst_n  : clock, async active-low reset
//   enable      : scanning on; low forces anodes off and returns to IDLE
//   load        : strobe capturing value/dp_mask into the shadow buffer
//   value       : BCD digits, digit 0 in [3:0]
//   dp_mask     : per-digit decimal point, 1 = lit
//   lz_blank    : suppress leading zeros (digit 0 never suppressed)
//   seg         : active-low segments, [7] = dp
//   an          : active-low anodes, at most one low
//   frame_done  : high during the cycle whose closing edge wraps the index
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int TW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] T_BLANK_END = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] T_SLOT_END  = TW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);

  state_t                        state_q;
  logic [TW-1:0]                 timer_q;
  logic [IW-1:0]                 idx_q;
  logic [NUM_DIGITS-1:0][3:0]    act_q, shd_q, act_nxt;
  logic [NUM_DIGITS-1:0]         act_dp_q, shd_dp_q, act_dp_nxt;
  logic                          pend_q;
  slot_t                         slot_q, slot_d;
  logic [7:0]                    seg_q, seg_d;
  logic [7:0]                    dec_disp;
  logic                          dec_unused;
  logic [NUM_DIGITS-1:0]         lz_mask;

  logic          start, slot_end, wrap, commit, blank_entry;
  logic [IW-1:0] nidx;

  assign start       = (state_q == IDLE) && enable;
  assign slot_end    = (state_q == SHOW) && (timer_q == T_SLOT_END);
  assign wrap        = slot_end && (idx_q == IDX_LAST);
  assign commit      = enable && (start || wrap);
  assign blank_entry = enable && (start || slot_end);
  assign nidx        = (start || wrap) ? '0 : idx_q + 1'b1;
  assign frame_done  = enable && wrap;

  // Value that is active from the next edge on. A load landing on the
  // commit edge bypasses the shadow so it is not deferred a whole frame.
  always_comb begin
    act_nxt    = act_q;
    act_dp_nxt = act_dp_q;
    if (commit && load) begin
      act_nxt    = value;
      act_dp_nxt = dp_mask;
    end else if (commit && pend_q) begin
      act_nxt    = shd_q;
      act_dp_nxt = shd_dp_q;
    end
  end

  // Leading-zero scan from the top digit down: a digit is suppressed while
  // no nonzero digit has been seen at or above it.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (act_nxt[i] != 4'd0);
      lz_mask[i] = lz_blank && !seen && (i != 0);
    end
  end

  always_comb begin
    slot_d.code  = act_nxt[nidx];
    slot_d.blank = (act_nxt[nidx] > MAX_BCD) || lz_mask[nidx];
    slot_d.dp_n  = ~act_dp_nxt[nidx];
  end

  bcd_7seg u_dec (
    .bcd     (slot_q.code),
    .display (dec_disp)
  );
  assign dec_unused = dec_disp[7];

  always_comb begin
    seg_d         = SEG_OFF;
    seg_d[6:0]    = slot_q.blank ? SEG_BLANK7 : dec_disp[6:0];
    seg_d[DP_BIT] = slot_q.dp_n;
  end

  // Scan FSM and slot timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= BLANK;
          timer_q <= '0;
          idx_q   <= '0;
        end
        BLANK: begin
          timer_q <= timer_q + 1'b1;
          if (timer_q == T_BLANK_END) state_q <= SHOW;
        end
        SHOW: begin
          if (slot_end) begin
            state_q <= BLANK;
            timer_q <= '0;
            idx_q   <= nidx;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Double buffer. Shadow/pending survive enable drops; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= '0;
      act_dp_q <= '0;
      shd_q    <= '0;
      shd_dp_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      act_q    <= act_nxt;
      act_dp_q <= act_dp_nxt;
      if (load) begin
        shd_q    <= value;
        shd_dp_q <= dp_mask;
      end
      if (load)        pend_q <= !commit;
      else if (commit) pend_q <= 1'b0;
    end
  end

  // Decoder input captured on BLANK entry, decoded pattern one cycle later,
  // so seg has settled before SHOW drives the anode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      seg_q  <= SEG_OFF;
    end else begin
      if (blank_entry) slot_q <= slot_d;
      seg_q <= seg_d;
    end
  end

  assign seg = (state_q == IDLE) ? SEG_OFF : seg_q;

  always_comb begin
    an = '1;
    if (state_q == SHOW) an[idx_q] = 1'b0;
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized and directed checks of seg7_scan_ctrl
// against a frame-level reference model (N=4, 8-cycle slots, 2-cycle gap).
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int D = 8;
  localparam int B = 2;
  localparam int F = N * D;

  localparam logic [6:0] PAT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst_n, enable, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: t = cycles since scanning started (-1 = idle).
  int          t = -1;
  logic [15:0] act_val = '0, nxt_val = '0;
  logic [3:0]  act_dp = '0, nxt_dp = '0;
  bit          have = 1'b0;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an(int tt);
    logic [3:0] one;
    one = 4'b0001;
    if (tt < 0 || tt % D < B) return 4'hF;
    return ~(one << ((tt % F) / D));
  endfunction

  function automatic logic exp_fd(int tt);
    return (tt >= 0) && (tt % F == F - 1);
  endfunction

  function automatic logic [7:0] exp_seg(int tt);
    int          s;
    logic [15:0] hi;
    logic [3:0]  d;
    logic [6:0]  p;
    if (tt < 0) return 8'hFF;
    s  = (tt % F) / D;
    hi = act_val >> (4 * s);
    d  = hi[3:0];
    if (d > 9 || (lz_blank && s > 0 && hi == 16'd0)) p = 7'h7F;
    else p = PAT[d];
    return {~act_dp[s], p};
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  // Drive one clock of stimulus and advance the model at that edge.
  task automatic tick(input logic en_i, input logic ld_i,
                      input logic [15:0] v_i, input logic [3:0] dp_i);
    enable  = en_i;
    load    = ld_i;
    value   = v_i;
    dp_mask = dp_i;
    @(posedge clk);
    if (!en_i) t = -1;
    else t = t + 1;
    if (ld_i) begin
      nxt_val = v_i;
      nxt_dp  = dp_i;
      have    = 1'b1;
    end
    if (en_i && t % F == 0 && have) begin
      act_val = nxt_val;
      act_dp  = nxt_dp;
      have    = 1'b0;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic model_reset();
    t       = -1;
    act_val = '0;
    act_dp  = '0;
    have    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    value = '0; dp_mask = '0; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 3;
    if (an !== 4'hF) begin miscompares++; $display("FAIL reset_an got=%b exp=1111", an); end
    if (seg !== 8'hFF) begin miscompares++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan_zero();
    for (int i = 0; i < 2 * F + 6; i++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      vectors += 2;
      if (an !== exp_an(t)) begin miscompares++; $display("FAIL zero_an t=%0d got=%b exp=%b", t, an, exp_an(t)); end
      if (frame_done !== exp_fd(t)) begin miscompares++; $display("FAIL zero_fd t=%0d got=%b exp=%b", t, frame_done, exp_fd(t)); end
      if (t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL zero_seg t=%0d got=%h exp=%h", t, seg, exp_seg(t)); end
      end
    end
  endtask

  task automatic test_load_midframe();
    for (int i = 0; i < F && t % F != 13; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b1, 1'b1, 16'h1234, 4'h0);
    for (int i = 0; i < 2 * F; i++) begin
      tick(1'b1, 1'b0, 16'hFFFF, 4'hF);
      vectors += 2;
      if (an !== exp_an(t)) begin miscompares++; $display("FAIL mid_an t=%0d got=%b exp=%b", t, an, exp_an(t)); end
      if (frame_done !== exp_fd(t)) begin miscompares++; $display("FAIL mid_fd t=%0d got=%b exp=%b", t, frame_done, exp_fd(t)); end
      if (t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL mid_seg t=%0d got=%h exp=%h", t, seg, exp_seg(t)); end
      end
    end
  endtask

  // Loads while idle, then scans one frame with the given lz setting.
  task automatic test_pattern(input logic lz, input logic [15:0] v, input logic [3:0] dp);
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    lz_blank = lz;
    tick(1'b0, 1'b1, v, dp);
    for (int i = 0; i < F + 4; i++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      vectors++;
      if (an !== exp_an(t)) begin miscompares++; $display("FAIL pat_an v=%h t=%0d got=%b exp=%b", v, t, an, exp_an(t)); end
      if (t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL pat_seg v=%h lz=%b t=%0d got=%h exp=%h", v, lz, t, seg, exp_seg(t)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < F && t % F != 5; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b1, 1'b1, 16'h5555, 4'h1);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b1, 1'b1, 16'h9999, 4'h8);
    for (int i = 0; i < F && t % F != F - 1; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
    vectors++;
    if (frame_done !== 1'b1) begin miscompares++; $display("FAIL b2b_fd_before got=%b exp=1", frame_done); end
    for (int i = 0; i < F; i++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      if (t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL b2b_seg t=%0d got=%h exp=%h", t, seg, exp_seg(t)); end
      end
    end
    // Load on the frame_done cycle itself lands in the very next frame.
    for (int i = 0; i < F && t % F != F - 1; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b1, 1'b1, 16'h4321, 4'h2);
    for (int i = 0; i < F; i++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      vectors++;
      if (an !== exp_an(t)) begin miscompares++; $display("FAIL edge_an t=%0d got=%b exp=%b", t, an, exp_an(t)); end
      if (t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL edge_seg t=%0d got=%h exp=%h", t, seg, exp_seg(t)); end
      end
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < F && t % F != 2 * D + 4; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    vectors += 3;
    if (an !== 4'hF) begin miscompares++; $display("FAIL drop_an got=%b exp=1111", an); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL drop_fd got=%b exp=0", frame_done); end
    if (seg !== 8'hFF) begin miscompares++; $display("FAIL drop_seg got=%h exp=ff", seg); end
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    for (int i = 0; i < F + 4; i++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      vectors += 2;
      if (an !== exp_an(t)) begin miscompares++; $display("FAIL reen_an t=%0d got=%b exp=%b", t, an, exp_an(t)); end
      if (frame_done !== exp_fd(t)) begin miscompares++; $display("FAIL reen_fd t=%0d got=%b exp=%b", t, frame_done, exp_fd(t)); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < F && t % F != 2 * D + 3; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
    vectors++;
    if (an !== 4'b1011) begin miscompares++; $display("FAIL ares_pre_an got=%b exp=1011", an); end
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (an !== 4'hF) begin miscompares++; $display("FAIL ares_an got=%b exp=1111", an); end
    if (seg !== 8'hFF) begin miscompares++; $display("FAIL ares_seg got=%h exp=ff", seg); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL ares_fd got=%b exp=0", frame_done); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < F; i++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      if (t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL ares_seg_after t=%0d got=%h exp=%h", t, seg, exp_seg(t)); end
      end
    end
  endtask

  task automatic test_random();
    logic en, ld;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) != 0);
      ld = ($urandom_range(0, 19) == 0);
      if (!en) lz_blank = 1'($urandom_range(0, 1));
      tick(en, ld, rand_val(), 4'($urandom_range(0, 15)));
      vectors += 2;
      if (an !== exp_an(t)) begin miscompares++; $display("FAIL rnd_an t=%0d got=%b exp=%b", t, an, exp_an(t)); end
      if (frame_done !== exp_fd(t)) begin miscompares++; $display("FAIL rnd_fd t=%0d got=%b exp=%b", t, frame_done, exp_fd(t)); end
      if (t < 0 || t % D >= B) begin
        vectors++;
        if (seg !== exp_seg(t)) begin miscompares++; $display("FAIL rnd_seg t=%0d got=%h exp=%h", t, seg, exp_seg(t)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load_midframe();
    test_pattern(1'b1, 16'h0070, 4'h0);
    test_pattern(1'b0, 16'h0070, 4'h0);
    test_pattern(1'b0, 16'h12B4, 4'b0100);
    test_pattern(1'b1, 16'h0000, 4'b1001);
    lz_blank = 1'b0;
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It shares a single `bcd_7seg` decoder across all digits. It holds a double-buffered BCD value, steps a digit index at a fixed refresh rate with an anti-ghosting blank gap, and drives one anode at a time. It sits between the register/counter logic producing the BCD value and the board segment/anode pins.

## Interface
- `NUM_DIGITS`, 4: number of digits, 2..8.
- `DIGIT_CYCLES`, 50000: clock cycles per digit slot, including blank gap.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all anodes off; must satisfy 2 ≤ `BLANK_CYCLES` < `DIGIT_CYCLES`.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: scanning on; when low all anodes are off.
- `load`, in, 1: one-cycle strobe that captures `value`/`dp_mask` into the shadow buffer.
- `value`, in, 4*`NUM_DIGITS`: BCD digits; digit 0 is bits [3:0] (rightmost).
- `dp_mask`, in, `NUM_DIGITS`: per-digit decimal point, 1 = lit.
- `lz_blank`, in, 1: leading-zero suppression enable.
- `seg`, out, 8: segments, active-low; [6:0] from decoder, [7] = dp.
- `an`, out, `NUM_DIGITS`: anodes, active-low, at most one low.
- `frame_done`, out, 1: one-cycle pulse at the end of each complete frame.

## Operation
- Reset values: `an` = all 1; `seg` = 8'hFF; `frame_done` = 0; active and shadow buffers = 0; pending = 0; digit index = 0; state = IDLE.
- Buffers:
  - `load` writes the shadow buffer and sets pending.
  - At a frame boundary, if pending is set, shadow is copied to active and pending is cleared.
  - If `load` coincides with a boundary, the new input is committed directly to active and pending stays 0.
  - A later `load` before the boundary overwrites the shadow; the last value wins.
- FSM states:
  - IDLE: `an` off and `seg` = FF. Moves to BLANK when `enable`=1, with index 0 and pending committed on entry.
  - BLANK: `an` off. The decoder input is set to the active digit[index]. Lasts `BLANK_CYCLES` cycles, then moves to SHOW.
  - SHOW: `an[index]`=0 and `seg` = registered decoded pattern. Lasts `DIGIT_CYCLES`−`BLANK_CYCLES` cycles, then moves to BLANK with index+1.
  - After index `NUM_DIGITS`−1, the index wraps to 0. That wrap is the frame boundary: `frame_done` pulses and the commit is applied.
- Blanked digits show `seg[6:0]` = 7'h7F with the anode still driven:
  - BCD code > 9.
  - With `lz_blank`=1: a zero digit above the highest nonzero digit. Digit 0 is never zero-suppressed.
- Decimal point: `seg[7]` = ~`dp_mask[index]` (from the active copy). The dp of a blanked digit still follows the mask.
- `enable` falling in any state: next cycle `an` = all 1, state = IDLE, index = 0, no `frame_done` pulse. The shadow buffer and pending flag are kept.
- Async reset mid-frame: all outputs take reset values immediately.

## Timing
- One slot = `DIGIT_CYCLES` cycles; one frame = `NUM_DIGITS`×`DIGIT_CYCLES` cycles.
- Decoder input is registered on BLANK entry. The `bcd_7seg` output is registered into `seg` one cycle later, so `seg` is stable before SHOW asserts the anode.
- From `enable` rising at edge k: BLANK occupies cycles k+1..k+`BLANK_CYCLES`, and `an[0]` goes low at k+`BLANK_CYCLES`+1.
- `frame_done` is high for the one cycle in which the index wraps. The committed value is visible from digit 0's BLANK of the following frame.
- A `load` lands mid-frame never alters the digits of the current frame; no tearing.
- Slot timer width is clog2(`DIGIT_CYCLES`); index width is clog2(`NUM_DIGITS`) with a minimum of 1.

## Structure
- Package `seg7_pkg`:
  - state enum {IDLE, BLANK, SHOW}.
  - `SEG_OFF` = 8'hFF.
  - `SEG_BLANK7` = 7'h7F.
  - `DP_BIT` = 7.
  - `MAX_BCD` = 9.
- One sub-module: the existing `bcd_7seg` (`bcd`[3:0] → `display`[7:0]), instantiated once. Only `display`[6:0] is used.
- Leading-zero mask is a combinational priority scan over the active buffer.

## Test plan
All scenarios use `NUM_DIGITS`=4, `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2.
1. Reset, then `enable`=1 with no load → after 2 cycles `an` = 4'b1110 and `seg[6:0]` = pattern for 0. Anodes step 1110→1101→1011→0111 every 8 cycles. `frame_done` pulses every 32 cycles.
2. `load` `value`=16'h1234 mid-frame → the current frame still shows 0000. From the next frame the digits show 4,3,2,1 on `an[0..3]`.
3. `value`=16'h0070, `lz_blank`=1 → digits 3 and 2 show 7F, digit 1 shows 7, digit 0 shows 0. With `lz_blank`=0 all four digits are lit.
4. Digit code 4'hB in position 1 → `seg[6:0]`=7F during `an`=1101. `dp_mask`=4'b0100 → `seg[7]`=0 only while `an`=1011.
5. `load` 16'h5555 then 16'h9999 in the same frame → the next frame shows 9999. A `load` exactly on the `frame_done` cycle is committed at that boundary.
6. `enable` drops during digit 2's SHOW → next cycle `an`=1111 and no `frame_done`. On re-enable, scanning restarts at digit 0. `rst_n` pulse mid-SHOW → `an`=1111 and `seg`=FF asynchronously.
